scroll_scheduler: RTL and testbench

Owns the scrolling waveform framebuffer (HEIGHT rows × WIDTH bits) and sequences every write to it: erase after reset or on request, a periodic scroll tick, a one-cycle column fetch from the sample buffer, and a row-by-row shift that inserts the fetched column. It also serves the video driver's pixel reads every cycle. It sits between the sample buffer, which produces columns, and the pixel-colour stage that feeds the video driver.

---
 rtl/scroll_sched_pkg.sv | 20 ++
 rtl/scroll_tick_timer.sv | 41 ++++
 rtl/scroll_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_scroll_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_sched_pkg.sv
// Shared types and default sizing for the scrolling waveform framebuffer scheduler.
package scroll_sched_pkg;

    typedef enum logic [1:0] {
        ST_ERASE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FETCH = 2'd2,
        ST_SHIFT = 2'd3
    } state_t;

    localparam int DEF_WIDTH       = 100;
    localparam int DEF_HEIGHT      = 100;
    localparam int DEF_TICK_CYCLES = 500000;

    // Row-counter width; a single-row buffer still needs one counter bit.
    function automatic int row_w(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

endpackage

// File: rtl/scroll_tick_timer.sv
// Scroll tick timer: counts 0..TICK_CYCLES-1 while running, done at the terminal count.
// restart clears the count; hold parks it at the terminal count instead of wrapping.
module scroll_tick_timer
    import scroll_sched_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic restart,
    input  logic hold,
    output logic done
);

    localparam int CW = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = hold ? LAST : '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/scroll_scheduler.sv
// Scrolling waveform framebuffer: erase, periodic scroll tick, column fetch, row-by-row shift.
// Build option SCROLL_SCHED_RD_BLANK_EN forces pixel to 0 while the frame is being erased.
//
// state    | meaning
// ERASE    | clear one row per cycle, rows 0..HEIGHT-1
// WAIT     | tick timer running; freeze parks it at the terminal count
// FETCH    | one cycle, col_ready high, capture column (or zero on underrun)
// SHIFT    | shift fetched column into one row per cycle at x=0
module scroll_scheduler
    import scroll_sched_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              clear,
    input  logic              freeze,
    input  logic              col_valid,
    input  logic [HEIGHT-1:0] col_data,
    output logic              col_ready,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    output logic              pixel,
    output logic              busy,
    output logic [15:0]       scroll_count,
    output logic              underrun
);

    localparam int RW = row_w(HEIGHT);
    localparam int XW = $clog2(WIDTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);
    localparam logic [8:0]    X_LIM    = 9'(WIDTH);
    localparam logic [8:0]    Y_LIM    = 9'(HEIGHT);

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [HEIGHT-1:0] col_reg_q, col_reg_d;
    logic              clear_pend_q, clear_pend_d;
    logic              col_ready_q, col_ready_d;
    logic              busy_q, busy_d;
    logic              pixel_q, pixel_d;
    logic              underrun_q, underrun_d;
    logic [15:0]       scroll_count_q, scroll_count_d;

    logic [WIDTH-1:0]  fb_q [HEIGHT];
    logic              fb_we;
    logic [WIDTH-1:0]  fb_wdata;

    logic              tick_restart;
    logic              tick_done;
    logic              in_range;
    logic [RW-1:0]     y_idx;
    logic [XW-1:0]     x_idx;

    assign tick_restart = (state_q != ST_WAIT);

    scroll_tick_timer #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .restart (tick_restart),
        .hold    (freeze),
        .done    (tick_done)
    );

    assign in_range = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    assign y_idx    = y[RW-1:0];
    assign x_idx    = x[XW-1:0];

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        col_reg_d      = col_reg_q;
        clear_pend_d   = clear_pend_q;
        scroll_count_d = scroll_count_q;
        underrun_d     = 1'b0;
        fb_we          = 1'b0;
        fb_wdata       = '0;

        case (state_q)
            ST_ERASE: begin
                fb_we        = 1'b1;
                clear_pend_d = 1'b0;
                if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            ST_WAIT: begin
                if (clear) begin
                    state_d = ST_ERASE;
                end else if (tick_done && !freeze) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (clear) begin
                    clear_pend_d = 1'b1;
                end
                if (col_valid) begin
                    col_reg_d = col_data;
                end else begin
                    col_reg_d  = '0;
                    underrun_d = 1'b1;
                end
                row_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                fb_we    = 1'b1;
                fb_wdata = {fb_q[row_q][WIDTH-2:0], col_reg_q[row_q]};
                if (clear) begin
                    clear_pend_d = 1'b1;
                end
                if (row_q == LAST_ROW) begin
                    row_d          = '0;
                    scroll_count_d = scroll_count_q + 16'd1;
                    clear_pend_d   = 1'b0;
                    // A clear arriving on the final row still diverts to ERASE.
                    state_d        = (clear_pend_q || clear) ? ST_ERASE : ST_WAIT;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            default: begin
                state_d = ST_ERASE;
                row_d   = '0;
            end
        endcase

        col_ready_d = (state_d == ST_FETCH);
        busy_d      = (state_d != ST_WAIT);

        pixel_d = 1'b0;
        if (in_range) begin
            pixel_d = fb_q[y_idx][x_idx];
        end
`ifdef SCROLL_SCHED_RD_BLANK_EN
        if (state_q == ST_ERASE) begin
            pixel_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q        <= ST_ERASE;
            row_q          <= '0;
            col_reg_q      <= '0;
            clear_pend_q   <= 1'b0;
            col_ready_q    <= 1'b0;
            busy_q         <= 1'b1;
            pixel_q        <= 1'b0;
            underrun_q     <= 1'b0;
            scroll_count_q <= '0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            col_reg_q      <= col_reg_d;
            clear_pend_q   <= clear_pend_d;
            col_ready_q    <= col_ready_d;
            busy_q         <= busy_d;
            pixel_q        <= pixel_d;
            underrun_q     <= underrun_d;
            scroll_count_q <= scroll_count_d;
        end
    end

    // Array is not reset; the ERASE pass that follows reset clears it.
    always_ff @(posedge CLOCK_50) begin
        if (fb_we && !reset) begin
            fb_q[row_q] <= fb_wdata;
        end
    end

    assign col_ready    = col_ready_q;
    assign busy         = busy_q;
    assign pixel        = pixel_q;
    assign underrun     = underrun_q;
    assign scroll_count = scroll_count_q;

endmodule

// File: tb/tb_scroll_scheduler.sv
// Self-checking bench for scroll_scheduler (WIDTH=8, HEIGHT=4, TICK_CYCLES=10).
module tb_scroll_scheduler;

    logic        CLOCK_50;
    logic        reset;
    logic        clear;
    logic        freeze;
    logic        col_valid;
    logic [3:0]  col_data;
    logic        col_ready;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        pixel;
    logic        busy;
    logic [15:0] scroll_count;
    logic        underrun;

    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;
    int fetch_cyc  = 0;
    int fetch_prev = 0;
    int mcount     = 0;
    logic [7:0] mfb [4];

    scroll_scheduler #(
        .WIDTH      (8),
        .HEIGHT     (4),
        .TICK_CYCLES(10)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .clear       (clear),
        .freeze      (freeze),
        .col_valid   (col_valid),
        .col_data    (col_data),
        .col_ready   (col_ready),
        .x           (x),
        .y           (y),
        .pixel       (pixel),
        .busy        (busy),
        .scroll_count(scroll_count),
        .underrun    (underrun)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 4; r++) mfb[r] = 8'h00;
    endtask

    // Waits for col_ready; n = negedges elapsed from the call.
    task automatic wait_ready(output int n);
        n = 0;
        while (col_ready !== 1'b1 && n < 300) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("ready_seen", 32'(col_ready), 32'd1);
        fetch_prev = fetch_cyc;
        fetch_cyc  = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("idle_seen", 32'(busy), 32'd0);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            @(negedge CLOCK_50);
            n++;
        end
    endtask

    // Called in the FETCH cycle: apply the scroll to the model, then check underrun.
    task automatic scroll_step();
        logic [3:0] c;
        logic       v;
        v = col_valid;
        c = v ? col_data : 4'h0;
        for (int r = 0; r < 4; r++) mfb[r] = {mfb[r][6:0], c[r]};
        mcount++;
        @(negedge CLOCK_50);
        check("underrun_pulse", 32'(underrun), 32'(!v));
        @(negedge CLOCK_50);
        check("underrun_clear", 32'(underrun), 32'd0);
    endtask

    task automatic read_pixel(input int xi, input int yi, input string tag);
        logic e;
        x = 8'(xi);
        y = 8'(yi);
        @(negedge CLOCK_50);
        e = 1'b0;
        if (xi < 8 && yi < 4) e = mfb[yi][xi];
        check(tag, 32'(pixel), 32'(e));
    endtask

    task automatic read_frame(input string tag);
        for (int yi = 0; yi < 4; yi++)
            for (int xi = 0; xi < 8; xi++)
                read_pixel(xi, yi, tag);
    endtask

    initial begin
        int n;
        bit seen;

        reset = 1'b1; clear = 1'b0; freeze = 1'b0;
        col_valid = 1'b1; col_data = 4'b1010; x = 8'd0; y = 8'd0;
        model_clear();
        repeat (3) @(negedge CLOCK_50);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_col_ready", 32'(col_ready), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_count", 32'(scroll_count), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);

        // Erase after reset, then first tick.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            check("erase_busy", 32'(busy), 32'd1);
        end
        @(negedge CLOCK_50);
        check("erase_done", 32'(busy), 32'd0);
        wait_ready(n);
        check("first_ready_delay", 32'(n), 32'd10);
        scroll_step();
        freeze = 1'b1;
        wait_idle();
        check("count_first", 32'(scroll_count), 32'(mcount));
        read_pixel(0, 1, "first_col_y1");
        read_pixel(0, 0, "first_col_y0");
        read_frame("frame_first");

        // Three back-to-back scrolls: F, 0, F.
        col_data = 4'hF;
        freeze = 1'b0;
        wait_ready(n);
        check("unfreeze_fetch", 32'(n), 32'd1);
        scroll_step();
        col_data = 4'h0;
        wait_ready(n);
        check("scroll_period", 32'(fetch_cyc - fetch_prev), 32'd15);
        scroll_step();
        col_data = 4'hF;
        wait_ready(n);
        check("scroll_period", 32'(fetch_cyc - fetch_prev), 32'd15);
        scroll_step();
        freeze = 1'b1;
        wait_idle();
        check("count_three", 32'(scroll_count), 32'(mcount));
        read_pixel(0, 0, "row0_x0");
        read_pixel(1, 0, "row0_x1");
        read_pixel(2, 0, "row0_x2");
        read_frame("frame_three");

        // Underrun inserts a zero column.
        col_valid = 1'b0;
        col_data = 4'hF;
        freeze = 1'b0;
        wait_ready(n);
        scroll_step();
        col_valid = 1'b1;
        freeze = 1'b1;
        wait_idle();
        check("count_underrun", 32'(scroll_count), 32'(mcount));
        read_frame("frame_underrun");

        // Randomized columns and pixel reads, including out-of-range coordinates.
        for (int k = 0; k < 6; k++) begin
            col_valid = ($urandom_range(0, 3) != 0);
            col_data = 4'($urandom);
            freeze = 1'b0;
            wait_ready(n);
            scroll_step();
            freeze = 1'b1;
            wait_idle();
            check("count_rand", 32'(scroll_count), 32'(mcount));
            for (int j = 0; j < 4; j++)
                read_pixel(int'($urandom_range(0, 9)), int'($urandom_range(0, 5)), "pixel_rand");
        end
        col_valid = 1'b1;

        // Freeze held across the terminal count.
        col_data = 4'($urandom);
        freeze = 1'b0;
        wait_ready(n);
        scroll_step();
        wait_idle();
        repeat (3) @(negedge CLOCK_50);
        freeze = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge CLOCK_50);
            if (col_ready === 1'b1) seen = 1'b1;
        end
        check("frozen_no_ready", 32'(seen), 32'd0);
        col_data = 4'($urandom);
        freeze = 1'b0;
        wait_ready(n);
        check("freeze_release_fetch", 32'(n), 32'd1);
        scroll_step();
        freeze = 1'b1;
        wait_idle();
        read_frame("frame_freeze");

        // Clear while idle in WAIT.
        clear = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        count_busy(n);
        check("clear_wait_erase_len", 32'(n), 32'd4);
        model_clear();
        check("count_clear_wait", 32'(scroll_count), 32'(mcount));
        read_frame("frame_clear_wait");

        // Clear during SHIFT row 2: shift completes, then erase.
        col_data = 4'($urandom);
        freeze = 1'b0;
        wait_ready(n);
        scroll_step();
        @(negedge CLOCK_50);
        clear = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        count_busy(n);
        check("clear_shift_busy_len", 32'(n), 32'd5);
        freeze = 1'b1;
        model_clear();
        check("count_clear_shift", 32'(scroll_count), 32'(mcount));
        read_frame("frame_clear_shift");

        // Reset in the middle of a shift.
        col_data = 4'hF;
        freeze = 1'b0;
        wait_ready(n);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        freeze = 1'b1;
        mcount = 0;
        model_clear();
        check("midrst_count", 32'(scroll_count), 32'd0);
        count_busy(n);
        check("midrst_erase_len", 32'(n), 32'd4);
        read_frame("frame_midrst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
